// File: rtl/onehot_led_decoder.sv
// Decodes a 3-bit index or an active-low 7-seg digit into a one-hot LED vector.
// Each accepted request lights its LED for HOLD_CYCLES cycles, followed by GAP_CYCLES dark cycles.
`timescale 1ns/1ps
module onehot_led_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sel,
    input  logic [2:0] in_code,
    input  logic [6:0] in_dig,
    output logic [7:0] out_onehot,
    output logic       out_active,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    // A hold of zero would leave the LED dark, so it is promoted to one cycle.
    localparam int HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] count;

    // Returns {hit, idx}; hit is 0 when the pattern is not one of the eight digits.
    function automatic logic [3:0] dig_decode(input logic [6:0] dig);
        logic [3:0] r;
        case (dig)
            7'b1000000: r = {1'b1, 3'd0};
            7'b1111001: r = {1'b1, 3'd1};
            7'b0100100: r = {1'b1, 3'd2};
            7'b0110000: r = {1'b1, 3'd3};
            7'b0011001: r = {1'b1, 3'd4};
            7'b0010010: r = {1'b1, 3'd5};
            7'b0000010: r = {1'b1, 3'd6};
            7'b1111000: r = {1'b1, 3'd7};
            default:    r = 4'b0000;
        endcase
        return r;
    endfunction

    logic       accept;
    logic [3:0] dig_dec;
    logic [2:0] idx;
    logic       legal;
    logic       blank;

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign dig_dec  = dig_decode(in_dig);
    assign idx      = in_sel ? dig_dec[2:0] : in_code;
    assign legal    = !in_sel || dig_dec[3];
    assign blank    = (in_dig == 7'b1111111);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_onehot <= 8'h00;
            out_active <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            out_onehot <= 8'b1 << idx;
                            out_active <= 1'b1;
                            count      <= HOLD_LOAD;
                            state      <= SHOW;
                        end else if (!blank) begin
                            err <= 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (count == '0) begin
                        out_onehot <= 8'h00;
                        out_active <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            count <= GAP_LOAD;
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                GAP: begin
                    if (count == '0) state <= IDLE;
                    else             count <= count - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
